// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector,
// fetch FSM encoding and instruction size.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_FULL,
        S_DROP
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus: one outstanding word fetch.
interface pc_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/pc_fetch_unit_skid.sv
// One-entry {instr, pc} holding buffer used when ID stalls with the output full.
module fetch_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ack bus and hands instr/pc/pc+4
// to ID, keeping the branch delay slot across redirects.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    pc_fetch_unit_if.master imem,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [31:0]     if_pc,
    output logic [31:0]     if_pc4
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         pend_valid, pend_valid_next;
    logic [31:0]  pend_pc, pend_pc_next;
    logic [31:0]  drop_addr, drop_addr_next;
    logic         armed;
    logic         req;
    logic [31:0]  fetch_addr;
    logic         consume, accept;
    logic         out_load, out_refill, out_clear;
    logic         skid_load, skid_unload, skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_instr, skid_pc;

    // armed keeps req low in the first cycle out of reset
    assign req        = armed && (state == S_ISSUE || state == S_DROP);
    assign fetch_addr = (state == S_DROP) ? drop_addr : pc;
    assign imem.req   = req;
    assign imem.addr  = req ? fetch_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ISSUE;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            drop_addr  <= '0;
            armed      <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pend_valid <= pend_valid_next;
            pend_pc    <= pend_pc_next;
            drop_addr  <= drop_addr_next;
            armed      <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pend_valid_next = pend_valid;
        pend_pc_next    = pend_pc;
        drop_addr_next  = drop_addr;
        out_load        = 1'b0;
        out_refill      = 1'b0;
        out_clear       = 1'b0;
        skid_load       = 1'b0;
        skid_unload     = 1'b0;
        skid_clear      = 1'b0;
        consume         = if_valid && !stall;
        accept          = armed && (state == S_ISSUE) && imem.ack;

        if (redirect_valid && if_valid) begin
            // Delay slot already in the output: kill skid and any fetch in flight
            skid_clear      = 1'b1;
            pend_valid_next = 1'b0;
            pc_next         = redirect_pc;
            out_clear       = consume;
            case (state)
                S_ISSUE: begin
                    if (!imem.ack) begin
                        state_next     = S_DROP;
                        drop_addr_next = pc;
                    end
                end
                S_DROP:  if (imem.ack) state_next = S_ISSUE;
                default: state_next = S_ISSUE;
            endcase
        end else begin
            if (consume) begin
                if (skid_valid) begin
                    out_refill  = 1'b1;
                    skid_unload = 1'b1;
                end else begin
                    out_clear = 1'b1;
                end
            end
            if (accept) begin
                if (!if_valid || !stall) begin
                    out_load   = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    skid_load  = 1'b1;
                    state_next = S_FULL;
                end
                // A redirect landing with the delay-slot ack bypasses pend_pc
                if (redirect_valid)  pc_next = redirect_pc;
                else if (pend_valid) pc_next = pend_pc;
                else                 pc_next = pc + INSTR_BYTES;
                pend_valid_next = 1'b0;
            end else if (redirect_valid) begin
                pend_valid_next = 1'b1;
                pend_pc_next    = redirect_pc;
            end
            case (state)
                S_WAIT:  state_next = S_ISSUE;
                S_FULL:  if (!stall) state_next = S_ISSUE;
                S_DROP:  if (imem.ack) state_next = S_ISSUE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            if_pc4   <= '0;
        end else if (out_load) begin
            if_valid <= 1'b1;
            if_instr <= imem.rdata;
            if_pc    <= fetch_addr;
            if_pc4   <= fetch_addr + INSTR_BYTES;
        end else if (out_refill) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            if_pc4   <= skid_pc + INSTR_BYTES;
        end else if (out_clear) begin
            if_valid <= 1'b0;
        end
    end

    fetch_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .in_instr (imem.rdata),
        .in_pc    (fetch_addr),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

endmodule
